// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the PC, issues single-word
//               reads on the instruction memory port, and presents the fetched
//               word to decode. A CU redirect flushes the stage and restarts
//               fetching at the new address.
//               Optional macro FETCH_PREFETCH_EN adds a 2-entry prefetch FIFO
//               behind the output register, so fetching can continue while
//               decode is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_exec_stall,
  input  logic        i_mem_stall,
  input  logic        i_jump_valid,
  input  logic [31:0] i_jump_addr,
  output logic        o_fetch_stall,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_addr,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_rd,
  input  logic [31:0] i_imem_data,
  input  logic        i_imem_rdy
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;

  logic        stall;
  logic        consume;
  logic        rd_req;
  logic        handshake;
  logic [31:0] jump_target;

  assign stall       = i_exec_stall | i_mem_stall;
  assign consume     = valid & ~stall;
  assign jump_target = {i_jump_addr[31:2], 2'b00};

`ifdef FETCH_PREFETCH_EN
  // Prefetch FIFO: entries hold fetched word plus its address, oldest first.
  logic [31:0] fifo_data [2];
  logic [31:0] fifo_addr [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        out_free;
  logic        pop;
  logic        direct;
  logic        push;

  assign fifo_full  = (count == 2'd2);
  assign fifo_empty = (count == 2'd0);
  // Output register frees up this edge when empty or being consumed.
  assign out_free   = ~valid | consume;
  // Older FIFO entries must reach the output before any newly returned word.
  assign pop        = out_free & ~fifo_empty;
  assign direct     = out_free & fifo_empty & handshake;
  assign push       = handshake & ~direct;

  assign rd_req = (state == ST_RUN) & ~i_jump_valid
                & ~(valid & fifo_full & ~consume);
`else
  assign rd_req = (state == ST_RUN) & ~i_jump_valid & (~valid | consume);
`endif

  assign handshake     = rd_req & i_imem_rdy;
  assign o_imem_rd     = rd_req;
  assign o_imem_addr   = pc;
  assign o_instr       = instr;
  assign o_instr_addr  = instr_addr;
  assign o_fetch_stall = ~valid;

  // Next-state: BOOT lasts exactly one cycle, a redirect there also leaves it.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // PC: redirect wins, otherwise advance one word per accepted request.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc <= RESET_ADDR;
    end else if (i_jump_valid) begin
      pc <= jump_target;
    end else if (handshake) begin
      pc <= pc + 32'd4;
    end
  end

`ifdef FETCH_PREFETCH_EN
  // Output register: flushed on redirect, refilled from FIFO head first,
  // then directly from memory, otherwise emptied once consumed.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid      <= 1'b0;
      instr      <= NOP_WORD;
      instr_addr <= RESET_ADDR;
    end else if (i_jump_valid) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
    end else if (pop) begin
      valid      <= 1'b1;
      instr      <= fifo_data[rd_ptr];
      instr_addr <= fifo_addr[rd_ptr];
    end else if (direct) begin
      valid      <= 1'b1;
      instr      <= i_imem_data;
      instr_addr <= pc;
    end else if (consume) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
    end
  end

  // FIFO storage and pointers; a redirect empties it in the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_data[0] <= NOP_WORD;
      fifo_data[1] <= NOP_WORD;
      fifo_addr[0] <= RESET_ADDR;
      fifo_addr[1] <= RESET_ADDR;
    end else if (i_jump_valid) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= i_imem_data;
        fifo_addr[wr_ptr] <= pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end
`else
  // Output register: flushed on redirect, loaded on handshake, emptied once
  // consumed, held otherwise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid      <= 1'b0;
      instr      <= NOP_WORD;
      instr_addr <= RESET_ADDR;
    end else if (i_jump_valid) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
    end else if (handshake) begin
      valid      <= 1'b1;
      instr      <= i_imem_data;
      instr_addr <= pc;
    end else if (consume) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch. Memory model
//               returns addr ^ 32'hA5A5_0000; rdy is driven per cycle.
//               Prefetch checks are built only with FETCH_PREFETCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] RST_A = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] XORK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_exec_stall = 1'b0;
  logic        i_mem_stall = 1'b0;
  logic        i_jump_valid = 1'b0;
  logic [31:0] i_jump_addr = 32'h0;
  logic        o_fetch_stall;
  logic [31:0] o_instr;
  logic [31:0] o_instr_addr;
  logic [31:0] o_imem_addr;
  logic        o_imem_rd;
  logic [31:0] i_imem_data;
  logic        i_imem_rdy = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  assign i_imem_data = o_imem_addr ^ XORK;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_ADDR(RST_A),
    .NOP_WORD  (NOP)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_exec_stall (i_exec_stall),
    .i_mem_stall  (i_mem_stall),
    .i_jump_valid (i_jump_valid),
    .i_jump_addr  (i_jump_addr),
    .o_fetch_stall(o_fetch_stall),
    .o_instr      (o_instr),
    .o_instr_addr (o_instr_addr),
    .o_imem_addr  (o_imem_addr),
    .o_imem_rd    (o_imem_rd),
    .i_imem_data  (i_imem_data),
    .i_imem_rdy   (i_imem_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its BOOT cycle at posedge+1.
  task automatic reset_dut();
    nrst = 1'b0;
    i_exec_stall = 1'b0;
    i_mem_stall = 1'b0;
    i_jump_valid = 1'b0;
    i_jump_addr = 32'h0;
    i_imem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    i_imem_rdy = 1'b1;
    @(posedge clk);
    #2;
    tests_run++; if (o_fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL rst_stall got %b exp 1", o_fetch_stall); end
    tests_run++; if (o_instr !== NOP) begin tests_failed++; $display("FAIL rst_instr got %h exp %h", o_instr, NOP); end
    tests_run++; if (o_instr_addr !== RST_A) begin tests_failed++; $display("FAIL rst_iaddr got %h exp %h", o_instr_addr, RST_A); end
    tests_run++; if (o_imem_rd !== 1'b0) begin tests_failed++; $display("FAIL rst_rd got %b exp 0", o_imem_rd); end
  endtask

  task automatic test_boot_stream();
    reset_dut();
    #1;
    tests_run++; if (o_imem_rd !== 1'b0) begin tests_failed++; $display("FAIL boot_rd got %b exp 0", o_imem_rd); end
    tests_run++; if (o_fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL boot_stall got %b exp 1", o_fetch_stall); end
    tick(); #1;
    tests_run++; if (o_imem_rd !== 1'b1 || o_imem_addr !== 32'h100) begin tests_failed++; $display("FAIL run1_req got rd=%b addr=%h exp rd=1 addr=00000100", o_imem_rd, o_imem_addr); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h100 || o_instr !== 32'hA5A5_0100) begin tests_failed++; $display("FAIL stream0 got %h/%h exp 00000100/a5a50100", o_instr_addr, o_instr); end
    tests_run++; if (o_fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL stream0_stall got %b exp 0", o_fetch_stall); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h104 || o_fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL stream1 got %h stall=%b exp 00000104 stall=0", o_instr_addr, o_fetch_stall); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h108 || o_instr !== 32'hA5A5_0108) begin tests_failed++; $display("FAIL stream2 got %h/%h exp 00000108/a5a50108", o_instr_addr, o_instr); end
  endtask

  task automatic test_mem_wait();
    reset_dut();
    tick();               // RUN1: fetch 0x100
    tick();               // RUN2: request 0x104, memory not ready
    i_imem_rdy = 1'b0;
    #1;
    tests_run++; if (o_imem_rd !== 1'b1 || o_imem_addr !== 32'h104) begin tests_failed++; $display("FAIL wait_first got rd=%b addr=%h exp rd=1 addr=00000104", o_imem_rd, o_imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) i_imem_rdy = 1'b1;
      #1;
      tests_run++; if (o_imem_rd !== 1'b1 || o_imem_addr !== 32'h104) begin tests_failed++; $display("FAIL wait_req%0d got rd=%b addr=%h exp rd=1 addr=00000104", i, o_imem_rd, o_imem_addr); end
      tests_run++; if (o_fetch_stall !== 1'b1 || o_instr !== NOP) begin tests_failed++; $display("FAIL wait_out%0d got stall=%b instr=%h exp stall=1 instr=%h", i, o_fetch_stall, o_instr, NOP); end
    end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h104 || o_instr !== 32'hA5A5_0104 || o_fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL wait_done got %h/%h stall=%b exp 00000104/a5a50104 stall=0", o_instr_addr, o_instr, o_fetch_stall); end
  endtask

  task automatic test_stall_hold();
    reset_dut();
    repeat (4) tick();    // now presenting 0x108
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      i_mem_stall  = (i < 2);
      i_exec_stall = (i >= 2);
      #1;
      tests_run++; if (o_instr_addr !== 32'h108 || o_instr !== 32'hA5A5_0108 || o_fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL hold%0d got %h/%h stall=%b exp 00000108/a5a50108 stall=0", i, o_instr_addr, o_instr, o_fetch_stall); end
`ifndef FETCH_PREFETCH_EN
      tests_run++; if (o_imem_rd !== 1'b0) begin tests_failed++; $display("FAIL hold_rd%0d got %b exp 0", i, o_imem_rd); end
`endif
    end
    tick();
    i_mem_stall = 1'b0;
    i_exec_stall = 1'b0;
    #1;
`ifndef FETCH_PREFETCH_EN
    tests_run++; if (o_imem_rd !== 1'b1 || o_imem_addr !== 32'h10C) begin tests_failed++; $display("FAIL release_req got rd=%b addr=%h exp rd=1 addr=0000010c", o_imem_rd, o_imem_addr); end
`endif
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h10C || o_instr !== 32'hA5A5_010C) begin tests_failed++; $display("FAIL release_next got %h/%h exp 0000010c/a5a5010c", o_instr_addr, o_instr); end
  endtask

  task automatic test_jump_on_rdy();
    reset_dut();
    tick();               // RUN1
    tick();               // RUN2: redirect coincident with rdy
    i_jump_valid = 1'b1;
    i_jump_addr  = 32'h0000_2003;
    #1;
    tests_run++; if (o_imem_rd !== 1'b0) begin tests_failed++; $display("FAIL jump_rd got %b exp 0", o_imem_rd); end
    tick();
    i_jump_valid = 1'b0;
    #1;
    tests_run++; if (o_imem_rd !== 1'b1 || o_imem_addr !== 32'h2000) begin tests_failed++; $display("FAIL jump_req got rd=%b addr=%h exp rd=1 addr=00002000", o_imem_rd, o_imem_addr); end
    tests_run++; if (o_fetch_stall !== 1'b1 || o_instr !== NOP) begin tests_failed++; $display("FAIL jump_flush got stall=%b instr=%h exp stall=1 instr=%h", o_fetch_stall, o_instr, NOP); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h2000 || o_instr !== 32'hA5A5_2000 || o_fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL jump_first got %h/%h stall=%b exp 00002000/a5a52000 stall=0", o_instr_addr, o_instr, o_fetch_stall); end
  endtask

  task automatic test_jump_wrap();
    reset_dut();
    i_jump_valid = 1'b1;  // redirect during BOOT
    i_jump_addr  = 32'hFFFF_FFFE;
    #1;
    tests_run++; if (o_imem_rd !== 1'b0) begin tests_failed++; $display("FAIL wrap_boot_rd got %b exp 0", o_imem_rd); end
    tick();
    i_jump_valid = 1'b0;
    #1;
    tests_run++; if (o_imem_rd !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_req got rd=%b addr=%h exp rd=1 addr=fffffffc", o_imem_rd, o_imem_addr); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'hFFFF_FFFC || o_instr !== 32'h5A5A_FFFC) begin tests_failed++; $display("FAIL wrap_top got %h/%h exp fffffffc/5a5afffc", o_instr_addr, o_instr); end
    tests_run++; if (o_imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc got %h exp 00000000", o_imem_addr); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h0 || o_instr !== 32'hA5A5_0000) begin tests_failed++; $display("FAIL wrap_zero got %h/%h exp 00000000/a5a50000", o_instr_addr, o_instr); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    repeat (3) tick();    // presenting 0x104
    #2;
    nrst = 1'b0;          // mid-cycle, no clock edge
    #1;
    tests_run++; if (o_fetch_stall !== 1'b1 || o_instr !== NOP || o_instr_addr !== RST_A || o_imem_rd !== 1'b0) begin tests_failed++; $display("FAIL arst got stall=%b instr=%h addr=%h rd=%b exp 1/%h/%h/0", o_fetch_stall, o_instr, o_instr_addr, o_imem_rd, NOP, RST_A); end
    tick(); #1;
    tests_run++; if (o_fetch_stall !== 1'b1 || o_imem_rd !== 1'b0 || o_imem_addr !== RST_A) begin tests_failed++; $display("FAIL arst_hold got stall=%b rd=%b pc=%h exp 1/0/%h", o_fetch_stall, o_imem_rd, o_imem_addr, RST_A); end
    nrst = 1'b1;
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_prefetch();
    int reqs;
    reset_dut();
    repeat (4) tick();    // presenting 0x108
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      i_mem_stall = 1'b1;
      #1;
      if (o_imem_rd && i_imem_rdy) reqs++;
    end
    tests_run++; if (reqs != 2) begin tests_failed++; $display("FAIL pf_extra_reqs got %0d exp 2", reqs); end
    tests_run++; if (o_instr_addr !== 32'h108) begin tests_failed++; $display("FAIL pf_hold got %h exp 00000108", o_instr_addr); end
    tick();
    i_mem_stall = 1'b0;
    #1;
    tests_run++; if (o_imem_addr !== 32'h114) begin tests_failed++; $display("FAIL pf_pc got %h exp 00000114", o_imem_addr); end
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      tests_run++; if (o_instr_addr !== 32'h10C + 32'(4 * i) || o_fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL pf_drain%0d got %h stall=%b exp %h stall=0", i, o_instr_addr, o_fetch_stall, 32'h10C + 32'(4 * i)); end
    end
    // Redirect while FIFO is full must discard every buffered entry.
    reset_dut();
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      i_mem_stall = 1'b1;
      if (i == 2) begin
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h0000_3000;
      end
      #1;
    end
    tick();
    i_jump_valid = 1'b0;
    i_mem_stall = 1'b0;
    #1;
    tests_run++; if (o_fetch_stall !== 1'b1 || o_imem_addr !== 32'h3000) begin tests_failed++; $display("FAIL pf_jump_flush got stall=%b pc=%h exp 1/00003000", o_fetch_stall, o_imem_addr); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h3000) begin tests_failed++; $display("FAIL pf_jump_first got %h exp 00003000", o_instr_addr); end
    tick(); #1;
    tests_run++; if (o_instr_addr !== 32'h3004) begin tests_failed++; $display("FAIL pf_jump_second got %h exp 00003004", o_instr_addr); end
  endtask
`endif

  initial begin
    test_reset();
    test_boot_stream();
    test_mem_wait();
    test_stall_hold();
    test_jump_on_rdy();
    test_jump_wrap();
    test_async_reset();
`ifdef FETCH_PREFETCH_EN
    test_prefetch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
